// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: BOOT/RUN/HALT control with trap, redirect, stall and debug halt.
// Optional macro PC_MISALIGN_CHK_EN rejects misaligned redirect targets instead of truncating them.
module pc_sequencer #(
  parameter int unsigned          PC_WIDTH  = 32,
  parameter int unsigned          PC_STEP   = 4,
  parameter logic [PC_WIDTH-1:0]  RESET_VEC = '0,
  parameter int unsigned          CNT_WIDTH = 16
) (
  input  logic                 CPU_clk,
  input  logic                 CPU_rst_n,
  input  logic                 PCWrite,
  input  logic                 Redirect_Valid,
  input  logic [PC_WIDTH-1:0]  Redirect_Target,
  input  logic                 Trap_Valid,
  input  logic [PC_WIDTH-1:0]  Trap_Vec,
  input  logic                 Halt_Req,
  input  logic                 Resume_Req,
  output logic [PC_WIDTH-1:0]  PC,
  output logic [PC_WIDTH-1:0]  PC_Plus_Step,
  output logic                 PC_Valid,
  output logic                 Halted,
  output logic                 Misalign_Err,
  output logic [PC_WIDTH-1:0]  Misalign_Addr,
  output logic [CNT_WIDTH-1:0] Redirect_Count
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  localparam logic [PC_WIDTH-1:0] STEP     = PC_WIDTH'(PC_STEP);
  localparam logic [PC_WIDTH-1:0] LOW_MASK = STEP - PC_WIDTH'(1);

  state_t                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic                  valid_q, valid_d;
  logic                  halted_q, halted_d;
  logic                  merr_q, merr_d;
  logic [PC_WIDTH-1:0]   maddr_q, maddr_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  bump;
  logic                  redir_bad;
  logic [PC_WIDTH-1:0]   trap_pc, redir_pc;

  assign trap_pc  = Trap_Vec & ~LOW_MASK;
  assign redir_pc = Redirect_Target & ~LOW_MASK;
`ifdef PC_MISALIGN_CHK_EN
  assign redir_bad = |(Redirect_Target & LOW_MASK);
`else
  assign redir_bad = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    merr_d   = 1'b0;
    maddr_d  = maddr_q;
    cnt_d    = cnt_q;
    bump     = 1'b0;
    case (state_q)
      BOOT: begin
        pc_d     = RESET_VEC;
        valid_d  = 1'b1;
        halted_d = 1'b0;
        state_d  = RUN;
      end
      RUN: begin
        if (Trap_Valid) begin
          pc_d = trap_pc;
          bump = 1'b1;
        end else if (Redirect_Valid) begin
          if (redir_bad) begin
            merr_d  = 1'b1;
            maddr_d = Redirect_Target;
          end else begin
            pc_d = redir_pc;
            bump = 1'b1;
          end
        end else if (PCWrite && !Halt_Req) begin
          pc_d = pc_q + STEP;
        end
        // Halt wins over Resume; any trap/redirect above still lands in PC.
        if (Halt_Req) begin
          state_d  = HALT;
          valid_d  = 1'b0;
          halted_d = 1'b1;
        end
      end
      HALT: begin
        if (Trap_Valid || Resume_Req) begin
          state_d  = RUN;
          valid_d  = 1'b1;
          halted_d = 1'b0;
        end
        if (Trap_Valid) begin
          pc_d = trap_pc;
          bump = 1'b1;
        end
      end
      default: state_d = BOOT;
    endcase
    if (bump && (cnt_q != '1)) cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge CPU_clk) begin
    if (!CPU_rst_n) begin
      state_q  <= BOOT;
      pc_q     <= RESET_VEC - STEP;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      merr_q   <= 1'b0;
      maddr_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      merr_q   <= merr_d;
      maddr_q  <= maddr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign PC             = pc_q;
  assign PC_Plus_Step   = pc_q + STEP;
  assign PC_Valid       = valid_q;
  assign Halted         = halted_q;
  assign Misalign_Err   = merr_q;
  assign Misalign_Addr  = maddr_q;
  assign Redirect_Count = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed scenarios then random traffic against a rule-level model.
module tb_pc_sequencer;
  localparam int unsigned W  = 32;
  localparam int unsigned CW = 4;
  localparam logic [W-1:0] RV = 32'h0000_0000;

  logic          CPU_clk = 1'b0;
  logic          CPU_rst_n, PCWrite, Redirect_Valid, Trap_Valid, Halt_Req, Resume_Req;
  logic [W-1:0]  Redirect_Target, Trap_Vec;
  logic [W-1:0]  PC, PC_Plus_Step, Misalign_Addr;
  logic          PC_Valid, Halted, Misalign_Err;
  logic [CW-1:0] Redirect_Count;

  pc_sequencer #(.PC_WIDTH(W), .PC_STEP(4), .RESET_VEC(RV), .CNT_WIDTH(CW)) dut (
    .CPU_clk(CPU_clk), .CPU_rst_n(CPU_rst_n), .PCWrite(PCWrite),
    .Redirect_Valid(Redirect_Valid), .Redirect_Target(Redirect_Target),
    .Trap_Valid(Trap_Valid), .Trap_Vec(Trap_Vec),
    .Halt_Req(Halt_Req), .Resume_Req(Resume_Req),
    .PC(PC), .PC_Plus_Step(PC_Plus_Step), .PC_Valid(PC_Valid), .Halted(Halted),
    .Misalign_Err(Misalign_Err), .Misalign_Addr(Misalign_Addr), .Redirect_Count(Redirect_Count));

  always #5 CPU_clk = ~CPU_clk;

  typedef struct {
    logic [W-1:0] pc;
    logic         valid, halted, err;
    logic [W-1:0] addr;
    int           cnt;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   driving_done = 0;

  // Reference model: architectural view (booting/halted flags, plain integer arithmetic)
  bit           m_boot = 1, m_halted = 0, m_valid = 0, m_err = 0;
  logic [W-1:0] m_pc = '0, m_addr = '0;
  int           m_cnt = 0;

  function automatic logic [W-1:0] align(input logic [W-1:0] a);
    return a - (a % 4);
  endfunction

  task automatic count_one();
    if (m_cnt < (1 << CW) - 1) m_cnt++;
  endtask

  task automatic model_edge(input bit rst_n, pcw, rv, input logic [W-1:0] rt,
                            input bit tv, input logic [W-1:0] tvec, input bit hr, rr);
    m_err = 0;
    if (!rst_n) begin
      m_boot = 1; m_halted = 0; m_valid = 0; m_pc = RV - 4; m_addr = '0; m_cnt = 0;
    end else if (m_boot) begin
      m_boot = 0; m_pc = RV; m_valid = 1;
    end else if (m_halted) begin
      if (tv) begin m_pc = align(tvec); count_one(); end
      if (tv || rr) begin m_halted = 0; m_valid = 1; end
    end else begin
      if (tv) begin
        m_pc = align(tvec); count_one();
      end else if (rv) begin
`ifdef PC_MISALIGN_CHK_EN
        if (rt % 4 != 0) begin m_err = 1; m_addr = rt; end
        else begin m_pc = rt; count_one(); end
`else
        m_pc = align(rt); count_one();
`endif
      end else if (pcw && !hr) begin
        m_pc = m_pc + 4;
      end
      if (hr) begin m_halted = 1; m_valid = 0; end
    end
  endtask

  task automatic cyc(input bit rst_n, pcw, rv, input logic [W-1:0] rt,
                     input bit tv, input logic [W-1:0] tvec, input bit hr, rr);
    exp_t e;
    @(negedge CPU_clk);
    CPU_rst_n = rst_n; PCWrite = pcw; Redirect_Valid = rv; Redirect_Target = rt;
    Trap_Valid = tv; Trap_Vec = tvec; Halt_Req = hr; Resume_Req = rr;
    model_edge(rst_n, pcw, rv, rt, tv, tvec, hr, rr);
    e.pc = m_pc; e.valid = m_valid; e.halted = m_halted; e.err = m_err;
    e.addr = m_addr; e.cnt = m_cnt;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [W-1:0] got, want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, got, want);
    end
  endtask

  // Monitor: every edge presents a fetch state; pop and compare one expectation per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge CPU_clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("pc", PC, e.pc);
        chk("pc_plus_step", PC_Plus_Step, e.pc + 32'd4);
        chk("pc_valid", W'(PC_Valid), W'(e.valid));
        chk("halted", W'(Halted), W'(e.halted));
        chk("misalign_err", W'(Misalign_Err), W'(e.err));
        chk("misalign_addr", Misalign_Addr, e.addr);
        chk("redirect_count", W'(Redirect_Count), W'(e.cnt));
      end
    end
  end

  initial begin
    CPU_rst_n = 0; PCWrite = 0; Redirect_Valid = 0; Redirect_Target = '0;
    Trap_Valid = 0; Trap_Vec = '0; Halt_Req = 0; Resume_Req = 0;
    // Reset, boot, stall-free advance then hold
    cyc(0,0,0,0,0,0,0,0); cyc(0,1,1,32'h40,1,32'h80,1,0);
    cyc(1,0,1,32'h40,1,32'h80,1,1);
    cyc(1,0,1,32'h8,0,0,0,0);
    cyc(1,1,0,0,0,0,0,0); cyc(1,1,0,0,0,0,0,0); cyc(1,1,0,0,0,0,0,0);
    cyc(1,0,0,0,0,0,0,0); cyc(1,0,0,0,0,0,0,0);
    // Trap beats redirect while stalled
    cyc(1,0,1,32'h20,0,0,0,0);
    cyc(1,0,1,32'h40,1,32'h100,0,0);
    // Halt, hold, resume, then trap wakes with resume also high
    cyc(1,1,0,0,0,0,1,1);
    cyc(1,1,1,32'h200,0,0,0,0); cyc(1,1,1,32'h200,0,0,1,0); cyc(1,1,0,0,0,0,0,0);
    cyc(1,1,0,0,0,0,0,1);
    cyc(1,0,0,0,0,0,1,0);
    cyc(1,1,0,0,1,32'h303,0,1);
    // Halt with same-cycle redirect, then reset mid-HALT
    cyc(1,1,1,32'h500,0,0,1,0); cyc(0,1,0,0,0,0,0,1); cyc(1,0,0,0,0,0,0,0);
    // Wrap at top of address space
    cyc(1,0,1,32'hFFFF_FFFC,0,0,0,0); cyc(1,1,0,0,0,0,0,0);
    // Misaligned redirect target, then a redirect during misalign pulse aftermath
    cyc(1,1,1,32'h42,0,0,0,0); cyc(1,0,0,0,0,0,0,0); cyc(1,0,1,32'h81,1,32'h10,0,0);
    for (int i = 0; i < 20; i++) cyc(1,0,1,32'h1000 + 4*i,0,0,0,0);
    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      logic [W-1:0] rt, tvec;
      rt   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 | $urandom_range(0, 15) : $urandom;
      tvec = $urandom;
      cyc($urandom_range(0, 299) != 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 4) == 0, rt, $urandom_range(0, 9) == 0, tvec,
          $urandom_range(0, 11) == 0, $urandom_range(0, 3) == 0);
    end
    driving_done = 1;
  end

  initial begin
    int waited = 0;
    wait (driving_done);
    while (exp_q.size() != 0 && waited < 20) begin
      @(posedge CPU_clk);
      waited++;
    end
    #2;
    chk("drain", W'(exp_q.size()), W'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end
endmodule
